// File: rtl/control_multi_if.sv
// control_multi_if: opcode-in / control-out bundle between the multi-cycle controller and its datapath
//   opcode       6  IR[31:26] from the datapath
//   PCWrite..RegDst  mux selects and write enables driven by the controller
//   instr_done   1  final cycle of an instruction
//   illegal_op   1  unknown opcode seen in DECODE
//   state        4  controller state (debug)
//   master: controller side, slave: datapath side
interface control_multi_if;
   logic [5:0] opcode;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
   logic [3:0] state;
   modport master (
      input  opcode,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op, state
   );
   modport slave (
      output opcode,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op, state
   );
endinterface

// File: rtl/control_multi.sv
// control_multi: Moore FSM sequencing the multi-cycle MIPS datapath (LW/SW/R/BEQ/J/ADDI + illegal trap)
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, returns to FETCH
//   bus    control_multi_if.master: opcode in, all datapath controls out
module control_multi #(
   parameter logic [5:0] OP_RTYPE = 6'd0,
   parameter logic [5:0] OP_LW    = 6'd35,
   parameter logic [5:0] OP_SW    = 6'd43,
   parameter logic [5:0] OP_BEQ   = 6'd4,
   parameter logic [5:0] OP_J     = 6'd2,
   parameter logic [5:0] OP_ADDI  = 6'd8
) (
   input logic clk,
   input logic reset,
   control_multi_if.master bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
   } state_t;
   state_t st, nx;
   logic pc_write, pc_write_cond, mem_write, ir_write, reg_write, done;
   logic [5:0] op;
   logic legal;
   assign op = bus.opcode;
   assign legal = op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
   always_ff @(posedge clk or posedge reset)
      if (reset) st <= FETCH;
      else       st <= nx;
   always_comb begin
      nx            = FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      done          = 1'b0;
      bus.IorD      = 1'b0;
      bus.MemRead   = 1'b0;
      bus.MemtoReg  = 1'b0;
      bus.PCSource  = 2'b00;
      bus.ALUOp     = 2'b00;
      bus.ALUSrcA   = 1'b0;
      bus.ALUSrcB   = 2'b00;
      bus.RegDst    = 1'b0;
      case (st)
         FETCH: begin
            bus.MemRead = 1'b1;
            ir_write    = 1'b1;
            bus.ALUSrcB = 2'b01;
            pc_write    = 1'b1;
            nx          = DECODE;
         end
         DECODE: begin
            bus.ALUSrcB = 2'b11;
            done        = !legal;
            nx = (op == OP_LW || op == OP_SW) ? MEMADR :
                 op == OP_RTYPE ? EXEC :
                 op == OP_BEQ   ? BRANCH :
                 op == OP_J     ? JUMP :
                 op == OP_ADDI  ? ADDIEX : FETCH;
         end
         MEMADR, ADDIEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            nx = st == ADDIEX ? ADDIWB : op == OP_SW ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
            nx          = MEMWB;
         end
         MEMWB: begin
            reg_write    = 1'b1;
            bus.MemtoReg = 1'b1;
            done         = 1'b1;
         end
         MEMWR: begin
            mem_write = 1'b1;
            bus.IorD  = 1'b1;
            done      = 1'b1;
         end
         EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = 2'b10;
            nx          = RWB;
         end
         RWB: begin
            reg_write  = 1'b1;
            bus.RegDst = 1'b1;
            done       = 1'b1;
         end
         BRANCH: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUOp     = 2'b01;
            pc_write_cond = 1'b1;
            bus.PCSource  = 2'b01;
            done          = 1'b1;
         end
         JUMP: begin
            pc_write     = 1'b1;
            bus.PCSource = 2'b10;
            done         = 1'b1;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end
         default: nx = FETCH;
      endcase
   end
   // Reset already forces st to FETCH; gating the enables keeps the FETCH writes from firing while held
   assign bus.PCWrite     = pc_write & ~reset;
   assign bus.PCWriteCond = pc_write_cond & ~reset;
   assign bus.MemWrite    = mem_write & ~reset;
   assign bus.IRWrite     = ir_write & ~reset;
   assign bus.RegWrite    = reg_write & ~reset;
   assign bus.instr_done  = done & ~reset;
   assign bus.illegal_op  = st == DECODE && !legal && !reset;
   assign bus.state       = st;
endmodule

// File: tb/tb_control_multi.sv
// tb_control_multi: directed self-checking bench for control_multi
module tb_control_multi;
   logic clk = 1'b0;
   logic reset;
   int   n_run = 0, n_fail = 0;
   control_multi_if bus ();
   control_multi dut (.clk(clk), .reset(reset), .bus(bus.master));
   always #5 clk = ~clk;
   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst}
   function automatic logic [16:0] exp_cw(input logic [3:0] s);
      case (s)
         4'd0:  return 17'b1_0_0_1_0_1_0_00_00_0_01_0_0;
         4'd1:  return 17'b0_0_0_0_0_0_0_00_00_0_11_0_0;
         4'd2:  return 17'b0_0_0_0_0_0_0_00_00_1_10_0_0;
         4'd3:  return 17'b0_0_1_1_0_0_0_00_00_0_00_0_0;
         4'd4:  return 17'b0_0_0_0_0_0_1_00_00_0_00_1_0;
         4'd5:  return 17'b0_0_1_0_1_0_0_00_00_0_00_0_0;
         4'd6:  return 17'b0_0_0_0_0_0_0_00_10_1_00_0_0;
         4'd7:  return 17'b0_0_0_0_0_0_0_00_00_0_00_1_1;
         4'd8:  return 17'b0_1_0_0_0_0_0_01_01_1_00_0_0;
         4'd9:  return 17'b1_0_0_0_0_0_0_10_00_0_00_0_0;
         4'd10: return 17'b0_0_0_0_0_0_0_00_00_1_10_0_0;
         4'd11: return 17'b0_0_0_0_0_0_0_00_00_0_00_1_0;
         default: return 17'b0;
      endcase
   endfunction
   function automatic logic [16:0] cw();
      return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
              bus.MemtoReg, bus.PCSource, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.RegDst};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Runs one instruction from FETCH; seq holds expected states, nibble 0 first
   task automatic run(input string name, input logic [5:0] op, input int n, input logic [35:0] seq, input logic ill);
      bus.opcode = op;
      for (int i = 0; i < n; i++) begin
         logic [3:0] s;
         logic dn;
         s  = seq[4*i +: 4];
         dn = (s == 4'd4 || s == 4'd5 || s == 4'd7 || s == 4'd8 || s == 4'd9 || s == 4'd11) || (s == 4'd1 && ill);
         check($sformatf("%s state[%0d]", name, i), 32'(bus.state), 32'(s));
         check($sformatf("%s ctrl[%0d]", name, i), 32'(cw()), 32'(exp_cw(s)));
         check($sformatf("%s done[%0d]", name, i), 32'(bus.instr_done), 32'(dn));
         check($sformatf("%s illegal[%0d]", name, i), 32'(bus.illegal_op), 32'(s == 4'd1 && ill));
         step();
      end
   endtask
   initial begin
      reset = 1'b1;
      bus.opcode = 6'd35;
      repeat (3) step();
      check("rst state", 32'(bus.state), 32'd0);
      check("rst ctrl", 32'(cw()), 32'(17'b0_0_0_1_0_0_0_00_00_0_01_0_0));
      check("rst done", 32'(bus.instr_done), 32'd0);
      reset = 1'b0;
      #1;
      run("lw",   6'd35, 5, {16'h0, 20'h43210}, 1'b0);
      run("sw",   6'd43, 4, {20'h0, 16'h5210}, 1'b0);
      run("r",    6'd0,  4, {20'h0, 16'h7610}, 1'b0);
      run("addi", 6'd8,  4, {20'h0, 16'hBA10}, 1'b0);
      run("beq",  6'd4,  3, {24'h0, 12'h810}, 1'b0);
      run("j",    6'd2,  3, {24'h0, 12'h910}, 1'b0);
      run("ill",  6'd63, 2, {28'h0, 8'h10}, 1'b1);
      check("after ill state", 32'(bus.state), 32'd0);
      // opcode changes after MEMADR must not redirect the load
      bus.opcode = 6'd35;
      repeat (3) step();
      check("lw hold memrd", 32'(bus.state), 32'd3);
      bus.opcode = 6'd0;
      step();
      check("lw hold memwb", 32'(bus.state), 32'd4);
      step();
      check("lw hold fetch", 32'(bus.state), 32'd0);
      // asynchronous reset in MEMRD aborts the load before write-back
      bus.opcode = 6'd35;
      repeat (3) step();
      check("abort pre state", 32'(bus.state), 32'd3);
      #2 reset = 1'b1;
      #1;
      check("abort async state", 32'(bus.state), 32'd0);
      check("abort enables", 32'({bus.PCWrite, bus.PCWriteCond, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.instr_done, bus.illegal_op}), 32'd0);
      step();
      check("abort held state", 32'(bus.state), 32'd0);
      check("abort held regwrite", 32'(bus.RegWrite), 32'd0);
      reset = 1'b0;
      #1;
      check("abort resume fetch", 32'(bus.PCWrite), 32'd1);
      step();
      check("abort no memwb", 32'(bus.state), 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
